timer_scheduler: RTL and testbench

Multi-channel programmable timer built on one shared prescaler and one shared time-multiplexed decrement unit. A prescaler produces a single-cycle tick enable at TICK_HZ from clk; it is never a generated clock. On each tick a sweep FSM visits every channel once, decrements it, and reloads or disables it on expiry. Expiry events are queued as per-channel pending flags and delivered one at a time over a valid/ready event port with round-robin fairness.

---
 rtl/sched_pkg.sv | 10 +
 rtl/tick_prescaler.sv | 17 +
 rtl/timer_scheduler.sv | 123 ++++++++++++
 tb/tb_timer_scheduler.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/sched_pkg.sv
// sched_pkg: shared FSM state, mode encoding and prescale helper for timer_scheduler.
package sched_pkg;
  typedef enum logic {IDLE, SWEEP} state_e;
  localparam logic MODE_ONESHOT = 1'b0;
  localparam logic MODE_PERIODIC = 1'b1;
  // Returns 0 when a tick period cannot hold a full sweep plus an idle cycle.
  function automatic int calc_prescale(input int clk_hz, input int tick_hz, input int num_ch);
    return (clk_hz / tick_hz >= num_ch + 2) ? clk_hz / tick_hz : 0;
  endfunction
endpackage

// File: rtl/tick_prescaler.sv
// tick_prescaler: one-clk-wide tick enable every CLK_HZ/TICK_HZ cycles (not a generated clock).
module tick_prescaler #(
  parameter int CLK_HZ = 50000000,
  parameter int TICK_HZ = 1000
) (
  input  logic clk,
  input  logic reset_n,
  output logic tick
);
  localparam int PRESCALE = CLK_HZ / TICK_HZ;
  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  logic [PW-1:0] cnt_q;
  assign tick = cnt_q == PW'(PRESCALE - 1);
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) cnt_q <= '0;
    else cnt_q <= tick ? '0 : cnt_q + PW'(1);
endmodule

// File: rtl/timer_scheduler.sv
// timer_scheduler: multi-channel tick timer with one shared sweep decrementer and a round-robin event port.
// Define SCHED_TOGGLE_OUT_EN to add tog_out, a per-channel square wave that flips on every expiry.
module timer_scheduler
  import sched_pkg::*;
#(
  parameter int CLK_HZ = 50000000,
  parameter int TICK_HZ = 1000,
  parameter int NUM_CH = 4,
  parameter int CNT_W = 16,
  localparam int CW = $clog2(NUM_CH)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [CW-1:0]     cfg_ch,
  input  logic [CNT_W-1:0]  cfg_period,
  input  logic              cfg_periodic,
  output logic              evt_valid,
  input  logic              evt_ready,
  output logic [CW-1:0]     evt_ch,
  output logic [NUM_CH-1:0] overrun,
  output logic              tick,
  output logic              busy
`ifdef SCHED_TOGGLE_OUT_EN
  ,
  output logic [NUM_CH-1:0] tog_out
`endif
);
  localparam int PRESCALE = calc_prescale(CLK_HZ, TICK_HZ, NUM_CH);
  if (PRESCALE == 0) begin : g_bad_prescale
    $error("timer_scheduler: CLK_HZ/TICK_HZ must be at least NUM_CH+2");
  end
  state_e state_q, state_d;
  logic [CW-1:0] idx_q, idx_d, rr_q, rr_d, held_ch_q, pick;
  logic [CW:0] j;
  logic held_q, wr, acc;
  logic [CNT_W-1:0] cnt_q [NUM_CH], cnt_d [NUM_CH], per_q [NUM_CH], per_d [NUM_CH];
  logic [NUM_CH-1:0] mode_q, mode_d, en_q, en_d, pend_q, pend_d, ovr_q, ovr_d;
  logic [NUM_CH-1:0] expire, clear, wr_mask;
  tick_prescaler #(.CLK_HZ(CLK_HZ), .TICK_HZ(TICK_HZ)) u_prescaler (
    .clk(clk), .reset_n(reset_n), .tick(tick)
  );
  assign busy = state_q == SWEEP;
  assign cfg_ready = reset_n && state_q == IDLE;
  assign wr = cfg_valid && cfg_ready;
  assign evt_valid = |pend_q;
  assign acc = evt_valid && evt_ready;
  assign overrun = ovr_q;
  assign state_d = busy ? (idx_q == CW'(NUM_CH - 1) ? IDLE : SWEEP) : (tick ? SWEEP : IDLE);
  assign idx_d = busy ? idx_q + CW'(1) : '0;
  // First pending channel at or after rr_q, searched circularly; lowest offset wins.
  always_comb begin
    pick = '0;
    j = '0;
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      j = {1'b0, rr_q} + (CW+1)'(k);
      j = j >= (CW+1)'(NUM_CH) ? j - (CW+1)'(NUM_CH) : j;
      if (pend_q[j[CW-1:0]]) pick = j[CW-1:0];
    end
  end
  // A presented event keeps its channel until accepted, even if an earlier channel becomes pending.
  assign evt_ch = held_q ? held_ch_q : pick;
  assign rr_d = evt_ch == CW'(NUM_CH - 1) ? '0 : evt_ch + CW'(1);
  assign clear = acc ? NUM_CH'(1) << evt_ch : '0;
  assign wr_mask = wr ? NUM_CH'(1) << cfg_ch : '0;
  always_comb begin
    cnt_d = cnt_q;
    per_d = per_q;
    mode_d = mode_q;
    en_d = en_q;
    expire = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (wr && cfg_ch == CW'(c)) begin
        per_d[c] = cfg_period;
        cnt_d[c] = cfg_period;
        mode_d[c] = cfg_periodic;
        en_d[c] = |cfg_period;
      end else if (busy && idx_q == CW'(c) && en_q[c]) begin
        expire[c] = cnt_q[c] == CNT_W'(1);
        cnt_d[c] = expire[c] ? (mode_q[c] == MODE_PERIODIC ? per_q[c] : cnt_q[c]) : cnt_q[c] - CNT_W'(1);
        en_d[c] = !(expire[c] && mode_q[c] == MODE_ONESHOT);
      end
    end
  end
  // Set beats clear, so an expiry on the channel being accepted neither drops nor overruns.
  assign pend_d = (pend_q & ~clear) | expire;
  assign ovr_d = (ovr_q & ~wr_mask) | (expire & pend_q & ~clear);
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      idx_q <= '0;
      rr_q <= '0;
      held_q <= 1'b0;
      held_ch_q <= '0;
      cnt_q <= '{default: '0};
      per_q <= '{default: '0};
      mode_q <= '0;
      en_q <= '0;
      pend_q <= '0;
      ovr_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q <= idx_d;
      rr_q <= acc ? rr_d : rr_q;
      held_q <= evt_valid && !evt_ready;
      held_ch_q <= evt_ch;
      cnt_q <= cnt_d;
      per_q <= per_d;
      mode_q <= mode_d;
      en_q <= en_d;
      pend_q <= pend_d;
      ovr_q <= ovr_d;
    end
  end
`ifdef SCHED_TOGGLE_OUT_EN
  logic [NUM_CH-1:0] tog_q;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) tog_q <= '0;
    else tog_q <= tog_q ^ expire;
  assign tog_out = tog_q;
`endif
endmodule

// File: tb/tb_timer_scheduler.sv
// tb_timer_scheduler: directed scenarios plus random traffic against a time-based reference model.
module tb_timer_scheduler;
  localparam int CLK_HZ = 100, TICK_HZ = 10, NUM_CH = 4, CNT_W = 16;
  localparam int P = CLK_HZ / TICK_HZ, CW = $clog2(NUM_CH);
  logic clk = 1'b0, reset_n = 1'b0, cfg_valid = 1'b0, cfg_periodic = 1'b0, evt_ready = 1'b0;
  logic [CW-1:0] cfg_ch = '0;
  logic [CNT_W-1:0] cfg_period = '0;
  logic cfg_ready, evt_valid, tick, busy;
  logic [CW-1:0] evt_ch;
  logic [NUM_CH-1:0] overrun;
`ifdef SCHED_TOGGLE_OUT_EN
  logic [NUM_CH-1:0] tog_out;
`endif
  int n_cmp = 0, n_bad = 0;
  always #5 clk = ~clk;
  timer_scheduler #(.CLK_HZ(CLK_HZ), .TICK_HZ(TICK_HZ), .NUM_CH(NUM_CH), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset_n(reset_n), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_ch(cfg_ch),
    .cfg_period(cfg_period), .cfg_periodic(cfg_periodic), .evt_valid(evt_valid), .evt_ready(evt_ready),
    .evt_ch(evt_ch), .overrun(overrun), .tick(tick), .busy(busy)
`ifdef SCHED_TOGGLE_OUT_EN
    , .tog_out(tog_out)
`endif
  );
  // Reference model: n = clock edges since reset release; ticks and sweeps follow from n arithmetically.
  int n, rr, hch;
  bit held;
  int per [NUM_CH], left [NUM_CH];
  bit mode [NUM_CH], en [NUM_CH];
  logic [NUM_CH-1:0] pend, ovr, tog;
  int ev_cnt [NUM_CH];
  int ev_log [$];
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask
  function automatic bit m_busy();
    return n >= P && n % P < NUM_CH;
  endfunction
  function automatic int m_pick();
    if (held) return hch;
    for (int k = 0; k < NUM_CH; k++)
      if (pend[(rr + k) % NUM_CH]) return (rr + k) % NUM_CH;
    return 0;
  endfunction
  task automatic m_reset();
    n = 0; rr = 0; hch = 0; held = 0; pend = '0; ovr = '0; tog = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      per[c] = 0; left[c] = 0; mode[c] = 0; en[c] = 0;
    end
  endtask
  task automatic m_advance();
    bit b = m_busy();
    int ix = n % P;
    bit v = |pend;
    int ch = m_pick();
    bit acc = v && evt_ready;
    logic [NUM_CH-1:0] pold = pend;
    if (acc) begin
      pend[ch] = 1'b0;
      rr = (ch + 1) % NUM_CH;
    end
    if (cfg_valid && !b) begin
      per[cfg_ch] = int'(cfg_period); left[cfg_ch] = int'(cfg_period);
      mode[cfg_ch] = cfg_periodic; en[cfg_ch] = cfg_period != 0; ovr[cfg_ch] = 1'b0;
    end
    if (b && en[ix]) begin
      if (left[ix] == 1) begin
        if (pold[ix] && !(acc && ch == ix)) ovr[ix] = 1'b1;
        pend[ix] = 1'b1;
        tog[ix] = ~tog[ix];
        if (mode[ix]) left[ix] = per[ix];
        else en[ix] = 0;
      end else left[ix]--;
    end
    held = v && !evt_ready;
    hch = ch;
    n++;
  endtask
  task automatic compare();
    check("tick", tick, n % P == P - 1);
    check("busy", busy, m_busy());
    check("cfg_ready", cfg_ready, reset_n && !m_busy());
    check("evt_valid", evt_valid, |pend);
    if (|pend) check("evt_ch", evt_ch, m_pick());
    check("overrun", overrun, ovr);
`ifdef SCHED_TOGGLE_OUT_EN
    check("tog_out", tog_out, tog);
`endif
  endtask
  // Inputs are set before calling; the handshake seen here completes at the coming edge.
  task automatic step();
    if (evt_valid && evt_ready) begin
      ev_cnt[evt_ch]++;
      ev_log.push_back(int'(evt_ch));
    end
    @(posedge clk);
    if (reset_n) m_advance();
    @(negedge clk);
    compare();
  endtask
  task automatic clear_counts();
    for (int c = 0; c < NUM_CH; c++) ev_cnt[c] = 0;
    ev_log.delete();
  endtask
  task automatic run_ticks(input int k);
    int t = 0, g = 0;
    while (t < k && g < k * P + 50) begin
      step();
      if (tick) t++;
      g++;
    end
    check("tick_budget", t, k);
    repeat (NUM_CH + 3) step();
  endtask
  task automatic cfg_write(input int ch, input int period, input bit periodic);
    int g = 0;
    while (!cfg_ready && g < 50) begin
      step();
      g++;
    end
    check("cfg_wait", cfg_ready, 1);
    cfg_valid = 1'b1; cfg_ch = CW'(ch); cfg_period = CNT_W'(period); cfg_periodic = periodic;
    step();
    cfg_valid = 1'b0;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end
  initial begin
    int g, lo;
    m_reset();
    clear_counts();
    repeat (3) step();
    check("rst_outputs", {cfg_ready, evt_valid, tick, busy, overrun}, 0);
    reset_n = 1'b1;
    g = 0;
    do begin
      step();
      g++;
    end while (!tick && g < 50);
    check("first_tick_cycle", g + 1, P);
    check("no_evt_after_reset", evt_valid, 0);
    // Periodic P=3: events on ticks 3, 6, 9 of the next ten.
    repeat (2) step();
    evt_ready = 1'b1;
    clear_counts();
    cfg_write(0, 3, 1);
    run_ticks(10);
    check("ch0_p3_events", ev_cnt[0], 3);
    check("ch0_p3_others", ev_cnt[1] + ev_cnt[2] + ev_cnt[3], 0);
    cfg_write(0, 0, 0);
    // One-shot P=2: exactly one event.
    clear_counts();
    cfg_write(1, 2, 0);
    run_ticks(6);
    check("ch1_oneshot_events", ev_cnt[1], 1);
    check("ch1_oneshot_others", ev_cnt[0] + ev_cnt[2] + ev_cnt[3], 0);
    // cfg_valid held across a sweep stalls for exactly NUM_CH cycles.
    g = 0;
    while (!busy && g < 3 * P) begin
      step();
      g++;
    end
    cfg_valid = 1'b1; cfg_ch = 2'd3; cfg_period = 16'd2; cfg_periodic = 1'b1;
    lo = 1;
    while (!cfg_ready && lo < 20) begin
      step();
      if (!cfg_ready) lo++;
    end
    check("cfg_stall_cycles", lo, NUM_CH);
    clear_counts();
    step();
    cfg_valid = 1'b0;
    run_ticks(4);
    check("ch3_p2_events", ev_cnt[3], 2);
    cfg_write(3, 0, 1);
    repeat (3) step();
    clear_counts();
    run_ticks(4);
    check("disable_stops_events", ev_cnt[3], 0);
    // Asynchronous reset in the middle of a sweep with pending/overrun state live.
    cfg_write(2, 1, 1);
    evt_ready = 1'b0;
    run_ticks(2);
    check("pre_reset_overrun", overrun, 4'b0100);
    g = 0;
    while (!(busy && n % P == 2) && g < 3 * P) begin
      step();
      g++;
    end
    #2 reset_n = 1'b0;
    m_reset();
    clear_counts();
    #1;
    check("async_rst_busy", busy, 0);
    check("async_rst_state", {cfg_ready, evt_valid, overrun}, 0);
`ifdef SCHED_TOGGLE_OUT_EN
    check("async_rst_tog", tog_out, 0);
`endif
    repeat (2) step();
    reset_n = 1'b1;
    // P=1 on ch0 and ch2 with the consumer stalled builds overruns, then rr delivery order.
    cfg_write(0, 1, 1);
    cfg_write(2, 1, 1);
    run_ticks(3);
    check("overrun_0101", overrun, 4'b0101);
    clear_counts();
    evt_ready = 1'b1;
    repeat (3) step();
    check("evt_order_len", ev_log.size() >= 2, 1);
    check("evt_order_first", ev_log[0], 0);
    check("evt_order_second", ev_log[1], 2);
    cfg_write(0, 0, 0);
    cfg_write(2, 0, 0);
    // Random traffic against the model.
    repeat (1500) begin
      evt_ready = $urandom_range(0, 3) != 0;
      cfg_valid = $urandom_range(0, 7) == 0;
      cfg_ch = CW'($urandom_range(0, NUM_CH - 1));
      cfg_period = CNT_W'($urandom_range(0, 4));
      cfg_periodic = 1'($urandom_range(0, 1));
      step();
    end
    cfg_valid = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
